// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - serial line, configuration and FIFO read port of the UART receiver
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          rx_in;
    logic [15:0]   div;
    logic          data_rd;
    logic [31:0]   data;
    logic          error;
    logic          overrun;
    logic [LW-1:0] level;

    modport master (
        output rx_in, div, data_rd,
        input  data, error, overrun, level
    );

    modport slave (
        input  rx_in, div, data_rd,
        output data, error, overrun, level
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with mid-bit sampling feeding a circular receive FIFO
module uart_rx_fifo #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [15:0]            div_eff;
    state_t                 state;
    logic [15:0]            cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift_q;
    logic                   error_q;

    logic [7:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          level_q;
    logic                   overrun_q;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= bus.rx_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign div_eff = (bus.div < 16'd4) ? 16'd4 : bus.div;

    // Counter reload values are taken from div at the moment of each load only
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        cnt   <= (div_eff >> 1) - 16'd1;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (!rxs) begin
                        cnt     <= div_eff - 16'd1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        shift_q <= {rxs, shift_q[7:1]};
                        cnt     <= div_eff - 16'd1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (rxs) begin
                        state <= IDLE;
                    end else begin
                        error_q <= 1'b1;
                        state   <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push    = (state == STOP) && (cnt == 16'd0) && rxs;
    assign pop     = bus.data_rd && (level_q != '0);
    assign full    = (level_q == LW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push && !push_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign bus.data    = (level_q == '0) ? 32'hFFFF_FFFF : {24'h0, mem[rd_ptr]};
    assign bus.error   = error_q;
    assign bus.overrun = overrun_q;
    assign bus.level   = level_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized frame stimulus against a queue model of the receiver
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int SYNC  = 2;

    typedef struct {
        int         at;
        logic [7:0] b;
        bit         good;
    } ev_t;

    logic clk;
    logic rst;
    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks;
    int         errors;
    int         cyc;
    int         err_cnt;
    int         ovr_cnt;
    int         pop_mode;
    int         force_edge;
    bit         force_on_push;
    logic [7:0] q[$];
    ev_t        sched[$];
    bit         exp_err;
    bit         exp_ovr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Advances one clock: decides data_rd, applies the model for the coming edge, then compares
    task automatic tick();
        int  e;
        bit  pop_ok;
        ev_t s;
        e = cyc + 1;
        bus.data_rd = (e == force_edge) || (pop_mode == 2) ||
                      (pop_mode == 1 && $urandom_range(0, 3) == 0);
        exp_err = 1'b0;
        exp_ovr = 1'b0;
        if (rst) begin
            q.delete();
            sched.delete();
        end else begin
            pop_ok = bus.data_rd && (q.size() > 0);
            if (pop_ok) void'(q.pop_front());
            if (sched.size() > 0 && sched[0].at == e) begin
                s = sched.pop_front();
                if (!s.good)              exp_err = 1'b1;
                else if (q.size() < DEPTH) q.push_back(s.b);
                else                       exp_ovr = 1'b1;
            end
        end
        @(negedge clk);
        cyc++;
        if (bus.error === 1'b1)   err_cnt++;
        if (bus.overrun === 1'b1) ovr_cnt++;
        chk("level", 32'(bus.level), 32'(q.size()));
        chk("data", bus.data, (q.size() > 0) ? {24'h0, q[0]} : 32'hFFFF_FFFF);
        chk("error", 32'(bus.error), 32'(exp_err));
        chk("overrun", 32'(bus.overrun), 32'(exp_ovr));
    endtask

    // Bit k of the frame is driven for de edges starting at edge p0 + k*de
    task automatic send_frame(input logic [7:0] b, input int d, input bit stop,
                              input int low_after, input int abort_bit);
        int         de;
        int         h;
        int         p0;
        logic [9:0] bits;
        ev_t        s;
        de       = (d < 4) ? 4 : d;
        h        = de >> 1;
        bus.div  = 16'(d);
        bits     = {stop, b, 1'b0};
        p0       = cyc + 1;
        s.at     = p0 + SYNC + h + 9 * de;
        s.b      = b;
        s.good   = stop;
        sched.push_back(s);
        if (force_on_push) force_edge = s.at;
        for (int k = 0; k < 10; k++) begin
            if (k == abort_bit) begin
                rst       = 1'b1;
                bus.rx_in = 1'b1;
                repeat (3) tick();
                rst = 1'b0;
                repeat (4) tick();
                return;
            end
            bus.rx_in = bits[k];
            repeat (de) tick();
        end
        if (!stop) repeat (low_after) tick();
        bus.rx_in = 1'b1;
        repeat (2) tick();
    endtask

    task automatic glitch(input int g, input int d);
        int de;
        de        = (d < 4) ? 4 : d;
        bus.div   = 16'(d);
        bus.rx_in = 1'b0;
        repeat (g) tick();
        bus.rx_in = 1'b1;
        repeat (de + 2) tick();
    endtask

    task automatic pop_one();
        pop_mode = 2;
        tick();
        pop_mode = 0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; err_cnt = 0; ovr_cnt = 0;
        pop_mode = 0; force_edge = -1; force_on_push = 1'b0;
        rst = 1'b1; bus.rx_in = 1'b1; bus.div = 16'd16; bus.data_rd = 1'b0;
        repeat (3) tick();
        chk("reset_data", bus.data, 32'hFFFF_FFFF);
        chk("reset_level", 32'(bus.level), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        send_frame(8'h55, 16, 1'b1, 0, -1);
        chk("lit_55_data", bus.data, 32'h0000_0055);
        chk("lit_55_level", 32'(bus.level), 32'd1);
        pop_one();
        chk("lit_55_popped", bus.data, 32'hFFFF_FFFF);
        chk("lit_55_empty", 32'(bus.level), 32'd0);

        err_cnt = 0;
        glitch(4, 16);
        send_frame(8'hA3, 16, 1'b1, 0, -1);
        chk("lit_glitch_err", 32'(err_cnt), 32'd0);
        chk("lit_a3_data", bus.data, 32'h0000_00A3);
        pop_one();

        err_cnt = 0;
        send_frame(8'h3C, 16, 1'b0, 40, -1);
        chk("lit_break_errs", 32'(err_cnt), 32'd1);
        chk("lit_break_level", 32'(bus.level), 32'd0);
        send_frame(8'h81, 16, 1'b1, 0, -1);
        chk("lit_81_data", bus.data, 32'h0000_0081);
        pop_one();

        ovr_cnt = 0;
        for (int i = 0; i < 17; i++) send_frame(8'(i), 8, 1'b1, 0, -1);
        chk("lit_full_level", 32'(bus.level), 32'd16);
        chk("lit_full_ovr", 32'(ovr_cnt), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("lit_drain", bus.data, 32'(i));
            pop_one();
        end
        chk("lit_drain_empty", bus.data, 32'hFFFF_FFFF);

        ovr_cnt = 0;
        for (int i = 0; i < 16; i++) send_frame(8'(8'h10 + i), 8, 1'b1, 0, -1);
        force_on_push = 1'b1;
        send_frame(8'h77, 8, 1'b1, 0, -1);
        force_on_push = 1'b0;
        force_edge = -1;
        chk("lit_pp_level", 32'(bus.level), 32'd16);
        chk("lit_pp_ovr", 32'(ovr_cnt), 32'd0);
        for (int i = 0; i < 15; i++) begin
            chk("lit_pp_drain", bus.data, 32'(8'h11 + i));
            pop_one();
        end
        chk("lit_pp_last", bus.data, 32'h0000_0077);
        pop_one();

        err_cnt = 0;
        send_frame(8'hAA, 16, 1'b1, 0, 5);
        chk("lit_rst_level", 32'(bus.level), 32'd0);
        chk("lit_rst_err", 32'(err_cnt), 32'd0);
        send_frame(8'hC5, 16, 1'b1, 0, -1);
        chk("lit_c5_data", bus.data, 32'h0000_00C5);
        pop_one();

        pop_mode = 1;
        for (int n = 0; n < 40; n++) begin
            int r;
            int d;
            r = $urandom_range(0, 9);
            d = $urandom_range(2, 12);
            if (r == 0) glitch($urandom_range(1, ((d < 4) ? 4 : d) >> 1), d);
            else        send_frame(8'($urandom), d, r != 1, $urandom_range(0, 30), -1);
        end
        pop_mode = 2;
        repeat (20) tick();
        pop_mode = 0;
        tick();
        chk("lit_final_empty", 32'(bus.level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, 2..256.
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop stages on rx_in before any use.
REQ-003 clk  input  1  single clock; every register is updated on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
REQ-005 rx_in  input  1  asynchronous serial line, 8N1 format, idle high.
REQ-006 div  input  16  clock cycles per bit; values below 4 are treated as 4.
REQ-007 data_rd  input  1  pop strobe; one entry is removed per cycle it is high.
REQ-008 data  output  32  {24'h0, head byte} when the FIFO is not empty, else 32'hFFFF_FFFF.
REQ-009 error  output  1  one-cycle pulse on a framing error.
REQ-010 overrun  output  1  one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-011 level  output  $clog2(FIFO_DEPTH)+1  number of bytes currently held.

Function
REQ-012 rx_in SHALL pass through SYNC_STAGES flops, reset to 1; the receiver SHALL use only the last stage (rxs).
REQ-013 The receiver FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 IDLE: when rxs=0, load bit counter with (div>>1)-1 and go to START.
REQ-015 START: at counter zero, if rxs=0, load counter div-1, clear bit index, go to DATA; if rxs=1 (glitch), go to IDLE with no output.
REQ-016 DATA: at each counter zero, shift rxs into shift register LSB-first, reload div-1; after the 8th sample go to STOP.
REQ-017 STOP: at counter zero, if rxs=1, present byte for push and go to IDLE; if rxs=0, pulse error, discard byte, go to WAIT_HIGH.
REQ-018 WAIT_HIGH: stay until rxs=1, then go to IDLE (break lines produce no bytes and only one error pulse).
REQ-019 div SHALL be sampled at each counter load; a change mid-frame affects only later bits.
REQ-020 The FIFO SHALL be a circular buffer with read/write pointers wrapping modulo FIFO_DEPTH and level tracked separately.
REQ-021 Push at stop-sample with FIFO not full: byte written; data/level reflect it the next cycle.
REQ-022 Push with FIFO full and no pop in the same cycle: byte dropped, contents unchanged, overrun pulses next cycle.
REQ-023 Pop with FIFO empty: ignored; pointers and level unchanged; data stays 32'hFFFF_FFFF.
REQ-024 Simultaneous push and pop: both performed, level unchanged; when full, the push is accepted (pop frees the slot).
REQ-025 data SHALL be combinational from head entry and empty flag; no read latency.
REQ-026 data_rd held high N cycles SHALL pop min(N, available) entries.

Reset
REQ-027 On rst: FSM=IDLE, counters/shift register=0, sync flops=1, pointers=0, level=0, error=0, overrun=0, data=32'hFFFF_FFFF.
REQ-028 rst mid-frame SHALL abandon the frame with no push or error; reception restarts on the next falling edge after rst deasserts.
REQ-029 FIFO storage contents need not be reset.

Verification
REQ-030 div=16, send 0x55 -> data=32'h0000_0055 and level=1 one cycle after stop sample; pulse data_rd -> data=32'hFFFF_FFFF, level=0.
REQ-031 div=16, rx_in low 4 cycles then high -> no push, error=0, FSM back in IDLE; following frame 0xA3 received correctly.
REQ-032 div=16, send 0x3C with stop bit 0, line held low 40 cycles -> one error pulse, level=0; then frame 0x81 -> data=32'h0000_0081.
REQ-033 div=8, send 17 bytes 0x00..0x10 without pop -> level=16, overrun one pulse, pops return 0x00..0x0F in order, then 32'hFFFF_FFFF.
REQ-034 FIFO full, data_rd asserted on the push cycle of 0x77 -> level stays 16, no overrun, 0x77 is the last entry popped.
REQ-035 rst asserted during bit 4 of a frame -> level=0, no error; the next full frame 0xC5 is received as 32'h0000_00C5.
